// File: rtl/cpu_pkg.sv
// Shared types for the memory arbiter: FSM states, requester owners and the
// latched memory command.
package cpu_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned CNT_W  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    typedef enum logic {
        OWN_F = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic              byte_acc;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_cmd_t;

    // Saturating increment used by the starvation counter.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic [CNT_W-1:0] lim);
        return (v >= lim) ? lim : CNT_W'(v + 1'b1);
    endfunction

endpackage

// File: rtl/arb_prio.sv
// Fetch/data priority decision: data normally wins, fetch wins once it has
// been passed over STARVE_LIM times in a row.
module arb_prio
    import cpu_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 3
) (
    input  logic             f_req,
    input  logic             d_req,
    input  logic [CNT_W-1:0] starve_cnt,
    output owner_e           winner
);

    always_comb begin
        winner = OWN_D;
        if (f_req && (!d_req || (starve_cnt >= CNT_W'(STARVE_LIM)))) begin
            winner = OWN_F;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester (fetch/data) single-port memory arbiter with a bounded wait
// per access and anti-starvation for the fetch side.
module mem_arbiter
    import cpu_pkg::*;
#(
    parameter int unsigned STARVE_LIM = 3,
    parameter int unsigned TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              f_req,
    input  logic [DATA_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_byte,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_done,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic              mem_byte,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    state_e           state_q;
    owner_e           owner_q;
    logic [CNT_W-1:0] starve_q;
    logic [CNT_W-1:0] starve_d;
    logic [CNT_W-1:0] wait_q;
    owner_e           winner;
    mem_cmd_t         req_cmd;
    logic             timeout_c;
    logic             finish_c;

    arb_prio #(
        .STARVE_LIM (STARVE_LIM)
    ) u_arb_prio (
        .f_req      (f_req),
        .d_req      (d_req),
        .starve_cnt (starve_q),
        .winner     (winner)
    );

    // Command presented by whichever requester wins this cycle.
    always_comb begin
        req_cmd.we       = 1'b0;
        req_cmd.byte_acc = 1'b0;
        req_cmd.addr     = f_addr;
        req_cmd.wdata    = '0;
        if (winner == OWN_D) begin
            req_cmd.we       = d_we;
            req_cmd.byte_acc = d_byte;
            req_cmd.addr     = d_addr;
            req_cmd.wdata    = d_wdata;
        end
    end

    // Starvation count only moves when a grant is actually issued from IDLE.
    always_comb begin
        starve_d = starve_q;
        if (winner == OWN_F) begin
            starve_d = '0;
        end else if (f_req) begin
            starve_d = sat_inc(starve_q, CNT_W'(STARVE_LIM));
        end
    end

    assign timeout_c = (wait_q == CNT_W'(TIMEOUT - 1));
    assign finish_c  = (state_q == ST_ACCESS) && (mem_ready || timeout_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_F;
            starve_q  <= '0;
            wait_q    <= '0;
            f_gnt     <= 1'b0;
            f_done    <= 1'b0;
            d_gnt     <= 1'b0;
            d_done    <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_byte  <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            f_done <= 1'b0;
            d_done <= 1'b0;
            err    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (f_req || d_req) begin
                        state_q   <= ST_ACCESS;
                        owner_q   <= winner;
                        starve_q  <= starve_d;
                        wait_q    <= '0;
                        f_gnt     <= (winner == OWN_F);
                        d_gnt     <= (winner == OWN_D);
                        mem_en    <= 1'b1;
                        mem_we    <= req_cmd.we;
                        mem_byte  <= req_cmd.byte_acc;
                        mem_addr  <= req_cmd.addr;
                        mem_wdata <= req_cmd.wdata;
                    end
                end
                ST_ACCESS: begin
                    if (finish_c) begin
                        state_q  <= ST_DONE;
                        mem_en   <= 1'b0;
                        mem_we   <= 1'b0;
                        mem_byte <= 1'b0;
                        f_done   <= (owner_q == OWN_F);
                        d_done   <= (owner_q == OWN_D);
                        // A real memory response always beats the timeout.
                        if (mem_ready) begin
                            rdata <= mem_rdata;
                        end else begin
                            rdata <= '0;
                            err   <= 1'b1;
                        end
                    end else begin
                        wait_q <= CNT_W'(wait_q + 1'b1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                    f_gnt   <= 1'b0;
                    d_gnt   <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected completions,
// a monitor pops and compares on every done pulse.
module tb_mem_arbiter;
    import cpu_pkg::*;

    localparam int TMO = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_gnt, f_done;
    logic [15:0] f_addr;
    logic        d_req, d_we, d_byte, d_gnt, d_done;
    logic [15:0] d_addr, d_wdata;
    logic [15:0] rdata;
    logic        err;
    logic        mem_en, mem_we, mem_byte;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ready;

    typedef struct packed {
        logic        own_d;
        logic [15:0] rdata;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   dones_seen = 0;
    int   wait_cfg = -1;
    int   acc_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .STARVE_LIM (3),
        .TIMEOUT    (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .f_req     (f_req),
        .f_addr    (f_addr),
        .f_gnt     (f_gnt),
        .f_done    (f_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_byte    (d_byte),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_done    (d_done),
        .rdata     (rdata),
        .err       (err),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_byte  (mem_byte),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Memory model: raises mem_ready in ACCESS cycle number wait_cfg+1 (never if negative).
    always @(negedge clk) begin
        if (mem_en) begin
            mem_ready = (acc_cnt == wait_cfg);
            acc_cnt++;
        end else begin
            mem_ready = 1'b0;
            acc_cnt   = 0;
        end
    end

    // Monitor: every completion must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (err && !(f_done || d_done)) begin
                check("err_without_done", 64'(err), 64'(0));
            end
            if (f_done || d_done) begin
                dones_seen++;
                check("single_done", 64'(f_done & d_done), 64'(0));
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 64'({f_done, d_done}), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    check("done_owner", 64'(d_done), 64'(e.own_d));
                    check("done_rdata", 64'(rdata), 64'(e.rdata));
                    check("done_err", 64'(err), 64'(e.err));
                end
            end
        end
    end

    task automatic push_exp(input logic own_d, input logic [15:0] rd, input logic er);
        exp_t e;
        e.own_d = own_d;
        e.rdata = rd;
        e.err   = er;
        exp_q.push_back(e);
    endtask

    // One isolated request; checks grant latency, held mem_* fields and done latency.
    task automatic do_req(input string tag, input logic own_d, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic we, input logic bt,
                          input int wcfg, input logic [15:0] mrd,
                          input logic [15:0] exp_rd, input logic exp_err,
                          input int exp_lat, input logic drop_early);
        logic done_ok;
        logic [50:0] want;
        done_ok = 1'b0;
        @(negedge clk);
        wait_cfg  = wcfg;
        mem_rdata = mrd;
        push_exp(own_d, exp_rd, exp_err);
        if (own_d) begin
            d_addr = addr; d_wdata = wdata; d_we = we; d_byte = bt; d_req = 1'b1;
        end else begin
            f_addr = addr; f_req = 1'b1;
        end
        want = {1'b1, own_d & we, own_d & bt, addr, (own_d ? wdata : 16'h0000)};
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                check({tag, "_gnt"}, 64'({f_gnt, d_gnt}), 64'({~own_d, own_d}));
                if (drop_early) begin
                    f_req = 1'b0; d_req = 1'b0;
                    d_addr = ~addr; d_wdata = ~wdata; d_we = ~we;
                end
            end
            if (f_done || d_done) begin
                check({tag, "_latency"}, 64'(n), 64'(exp_lat));
                check({tag, "_done_state"}, 64'({mem_en, f_gnt, d_gnt}), 64'({1'b0, ~own_d, own_d}));
                done_ok = 1'b1;
                break;
            end
            check({tag, "_mem_hold"},
                  64'({mem_en, mem_we, mem_byte, mem_addr, (own_d ? mem_wdata : 16'h0000)}),
                  64'(want));
        end
        if (!done_ok) check({tag, "_done_timeout"}, 64'(0), 64'(1));
        f_req = 1'b0;
        d_req = 1'b0;
        @(negedge clk);
        check({tag, "_gnt_idle"}, 64'({f_gnt, d_gnt, mem_en}), 64'(0));
    endtask

    initial begin
        int start;
        rst = 1'b1;
        f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_byte = 1'b0; d_addr = '0; d_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({f_gnt, f_done, d_gnt, d_done, err, mem_en, mem_we, mem_byte,
                   rdata, mem_addr, mem_wdata}), 64'(0));
        rst = 1'b0;

        // Zero-wait fetch.
        do_req("fetch0", 1'b0, 16'hF800, 16'h0, 1'b0, 1'b0, 0, 16'h4034,
               16'h4034, 1'b0, 2, 1'b0);

        // Both requesters held: D, D, D, F, D.
        @(negedge clk);
        wait_cfg = 0; mem_rdata = 16'h5A5A;
        f_addr = 16'h1000; d_addr = 16'h2000; d_we = 1'b0; d_byte = 1'b0;
        push_exp(1'b1, 16'h5A5A, 1'b0);
        push_exp(1'b1, 16'h5A5A, 1'b0);
        push_exp(1'b1, 16'h5A5A, 1'b0);
        push_exp(1'b0, 16'h5A5A, 1'b0);
        push_exp(1'b1, 16'h5A5A, 1'b0);
        start = dones_seen;
        f_req = 1'b1; d_req = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            #1;
            if (dones_seen - start >= 5) break;
        end
        f_req = 1'b0; d_req = 1'b0;
        check("starve_done_count", 64'(dones_seen - start), 64'(5));
        check("starve_queue_empty", 64'(exp_q.size()), 64'(0));

        // Write with 3 wait cycles; requester drops and scrambles inputs after grant.
        do_req("write3", 1'b1, 16'h0200, 16'hBEEF, 1'b1, 1'b0, 3, 16'h1111,
               16'h1111, 1'b0, 5, 1'b1);

        // Byte read with one wait cycle.
        do_req("byte1", 1'b1, 16'h0301, 16'h0, 1'b0, 1'b1, 1, 16'h00AB,
               16'h00AB, 1'b0, 3, 1'b0);

        // Memory never answers: 15 ACCESS cycles then err with zero data.
        do_req("timeout", 1'b1, 16'h0400, 16'h0, 1'b0, 1'b0, -1, 16'hDEAD,
               16'h0000, 1'b1, TMO + 1, 1'b0);

        // Reset in the middle of an access.
        @(negedge clk);
        wait_cfg = -1; d_addr = 16'h0500; d_we = 1'b1; d_req = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_reset_access", 64'({d_gnt, mem_en, mem_we}), 64'(3'b111));
        #1 rst = 1'b1;
        #1 check("reset_mid_access", 64'({mem_en, mem_we, d_gnt, f_gnt}), 64'(0));
        d_req = 1'b0; d_we = 1'b0;
        start = dones_seen;
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1 check("no_done_after_reset", 64'(dones_seen - start), 64'(0));
        check("reset_rdata", 64'(rdata), 64'(0));

        do_req("post_reset", 1'b0, 16'hF802, 16'h0, 1'b0, 1'b0, 0, 16'h7777,
               16'h7777, 1'b0, 2, 1'b0);

        repeat (3) @(negedge clk);
        check("final_queue_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
